// File: rtl/icetap_jtag_tap.sv
// icetap_jtag_tap: IEEE 1149.1-style TAP controller for the icetap debug core.
// It contains the 16-state TAP FSM, the instruction register and its decode,
// the IDCODE and BYPASS data registers, and the TDO multiplexer.
// Handshake note: JTAG has no valid/ready. Each rising tck consumes one
// tms/tdi pair unconditionally, so a sample is "valid" on every edge and the
// TAP is always "ready".
module icetap_jtag_tap #(
  parameter int                   IR_LENGTH    = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1000_0A5F,
  parameter logic [IR_LENGTH-1:0] IR_EXTEST    = 4'h0,
  parameter logic [IR_LENGTH-1:0] IR_SCAN_N    = 4'h2,
  parameter logic [IR_LENGTH-1:0] IR_IDCODE    = 4'hE,
  parameter logic [IR_LENGTH-1:0] IR_BYPASS    = 4'hF
) (
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  input  logic       tdi,
  input  logic       icetap_tdo,
  output logic       tdo,
  output logic       tdo_ena,
  output logic       test_logic_reset,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       extest_ir,
  output logic       scan_n_ir,
  output logic       idcode_ir,
  output logic       bypass_ir,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e             state_q, state_d;
  logic [IR_LENGTH-1:0]   ir_q, ir_d;
  logic [IR_LENGTH-1:0]   ir_sr_q, ir_sr_d;
  logic [31:0]            idcode_sr_q, idcode_sr_d;
  logic                   bypass_sr_q, bypass_sr_d;

  // Value loaded into the IR shift register in Capture-IR: ...0001.
  localparam logic [IR_LENGTH-1:0] IR_CAPTURE = IR_LENGTH'(1);

  assign dbg_state_o = state_q;

  // State register with synchronous reset to Test-Logic-Reset.
  always_ff @(posedge tck) begin
    if (reset) state_q <= TLR;
    else       state_q <= state_d;
  end

  // Next-state logic: standard TAP transition table driven by tms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // State strobes: pure decode of the current state.
  always_comb begin
    test_logic_reset = 1'b0;
    capture_dr       = 1'b0;
    shift_dr         = 1'b0;
    update_dr        = 1'b0;
    capture_ir       = 1'b0;
    shift_ir         = 1'b0;
    update_ir        = 1'b0;
    case (state_q)
      TLR:     test_logic_reset = 1'b1;
      CAP_DR:  capture_dr       = 1'b1;
      SH_DR:   shift_dr         = 1'b1;
      UPD_DR:  update_dr        = 1'b1;
      CAP_IR:  capture_ir       = 1'b1;
      SH_IR:   shift_ir         = 1'b1;
      UPD_IR:  update_ir        = 1'b1;
      default: ;
    endcase
    tdo_ena = shift_dr | shift_ir;
  end

  // Instruction decode: one-hot, with every unlisted opcode acting as BYPASS.
  always_comb begin
    extest_ir = 1'b0;
    scan_n_ir = 1'b0;
    idcode_ir = 1'b0;
    bypass_ir = 1'b0;
    if (ir_q == IR_EXTEST)      extest_ir = 1'b1;
    else if (ir_q == IR_SCAN_N) scan_n_ir = 1'b1;
    else if (ir_q == IR_IDCODE) idcode_ir = 1'b1;
    else                        bypass_ir = 1'b1;
  end

  // Next values for the IR and data registers.
  // ir is forced to IDCODE whenever the FSM is about to sit in TLR, so the
  // decode already reads IDCODE on the first TLR cycle.
  always_comb begin
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    idcode_sr_d = idcode_sr_q;
    bypass_sr_d = bypass_sr_q;
    if (state_d == TLR)          ir_d = IR_IDCODE;
    else if (state_q == UPD_IR)  ir_d = ir_sr_q;
    case (state_q)
      CAP_IR: ir_sr_d = IR_CAPTURE;
      SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_LENGTH-1:1]};
      CAP_DR: begin
        bypass_sr_d = 1'b0;
        if (idcode_ir) idcode_sr_d = IDCODE_VALUE;
      end
      SH_DR: begin
        if (bypass_ir) bypass_sr_d = tdi;
        if (idcode_ir) idcode_sr_d = {tdi, idcode_sr_q[31:1]};
      end
      default: ;
    endcase
  end

  // IR and data register storage; reset abandons any partial shift.
  always_ff @(posedge tck) begin
    if (reset) begin
      ir_q        <= IR_IDCODE;
      ir_sr_q     <= '0;
      idcode_sr_q <= '0;
      bypass_sr_q <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      idcode_sr_q <= idcode_sr_d;
      bypass_sr_q <= bypass_sr_d;
    end
  end

  // TDO mux: the register block only drives out during Shift-DR of
  // EXTEST/SCAN_N; in Shift-IR our own IR shift register goes out.
  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_sr_q[0];
    end else if (shift_dr) begin
      if (idcode_ir)                   tdo = idcode_sr_q[0];
      else if (bypass_ir)              tdo = bypass_sr_q;
      else if (extest_ir || scan_n_ir) tdo = icetap_tdo;
    end
  end

endmodule

// File: tb/tb_icetap_jtag_tap.sv
// Testbench for icetap_jtag_tap: directed scans plus a random tms/tdi run,
// all compared against a table-driven TAP model kept in this file.
module tb_icetap_jtag_tap;

  // ---------------- clock / reset block ----------------
  logic tck = 1'b0;
  logic reset = 1'b0, tms = 1'b0, tdi = 1'b0, icetap_tdo = 1'b0;
  logic tdo, tdo_ena, test_logic_reset, capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;
  logic extest_ir, scan_n_ir, idcode_ir, bypass_ir;
  logic [3:0] dbg_state;

  always #5 tck = ~tck;

  icetap_jtag_tap dut (
    .tck(tck), .reset(reset), .tms(tms), .tdi(tdi), .icetap_tdo(icetap_tdo),
    .tdo(tdo), .tdo_ena(tdo_ena), .test_logic_reset(test_logic_reset),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .extest_ir(extest_ir), .scan_n_ir(scan_n_ir), .idcode_ir(idcode_ir),
    .bypass_ir(bypass_ir), .dbg_state_o(dbg_state)
  );

  // Output vector: {tdo, tdo_ena, tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir,
  //                 upd_ir, extest, scan_n, idcode, bypass}
  wire [12:0] dut_vec = {tdo, tdo_ena, test_logic_reset, capture_dr, shift_dr,
                         update_dr, capture_ir, shift_ir, update_ir,
                         extest_ir, scan_n_ir, idcode_ir, bypass_ir};

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  localparam int S_TLR = 0, S_RTI = 1, S_SELDR = 2, S_CAPDR = 3, S_SHDR = 4,
                 S_EX1DR = 5, S_PAUDR = 6, S_EX2DR = 7, S_UPDDR = 8,
                 S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11, S_EX1IR = 12,
                 S_PAUIR = 13, S_EX2IR = 14, S_UPDIR = 15;
  // Successor tables straight from the transition list (tms=0 / tms=1).
  int nxt0 [16] = '{S_RTI, S_RTI, S_CAPDR, S_SHDR, S_SHDR, S_PAUDR, S_PAUDR,
                    S_SHDR, S_RTI, S_CAPIR, S_SHIR, S_SHIR, S_PAUIR, S_PAUIR,
                    S_SHIR, S_RTI};
  int nxt1 [16] = '{S_TLR, S_SELDR, S_SELIR, S_EX1DR, S_EX1DR, S_UPDDR,
                    S_EX2DR, S_UPDDR, S_SELDR, S_TLR, S_EX1IR, S_EX1IR,
                    S_UPDIR, S_EX2IR, S_UPDIR, S_SELDR};

  int          m_st    = S_TLR;
  int unsigned m_ir    = 14;
  int unsigned m_ir_sr = 0;
  int unsigned m_idc   = 0;
  int unsigned m_byp   = 0;
  bit          model_valid = 1'b0;

  function automatic logic [12:0] model_out(input logic ice);
    logic ext, scn, idc, byp, o;
    ext = (m_ir == 0);
    scn = (m_ir == 2);
    idc = (m_ir == 14);
    byp = !(ext || scn || idc);
    o = 1'b0;
    if (m_st == S_SHIR)      o = m_ir_sr[0];
    else if (m_st == S_SHDR) o = idc ? m_idc[0] : (byp ? m_byp[0] : ice);
    return {o, (m_st == S_SHDR || m_st == S_SHIR), m_st == S_TLR,
            m_st == S_CAPDR, m_st == S_SHDR, m_st == S_UPDDR,
            m_st == S_CAPIR, m_st == S_SHIR, m_st == S_UPDIR,
            ext, scn, idc, byp};
  endfunction

  task automatic model_update(input logic t, input logic d, input logic rst);
    int nx;
    if (rst) begin
      m_st = S_TLR; m_ir = 14; m_ir_sr = 0; m_idc = 0; m_byp = 0;
      return;
    end
    nx = t ? nxt1[m_st] : nxt0[m_st];
    if (m_st == S_UPDIR) m_ir = m_ir_sr;
    if (nx == S_TLR)     m_ir = 14;
    if (m_st == S_CAPIR) m_ir_sr = 1;
    if (m_st == S_SHIR)  m_ir_sr = (m_ir_sr >> 1) | (int'(d) << 3);
    if (m_st == S_CAPDR) begin
      m_byp = 0;
      if (m_ir == 14) m_idc = 32'h1000_0A5F;
    end
    if (m_st == S_SHDR) begin
      if (m_ir == 14) m_idc = (m_idc >> 1) | (int'(d) << 31);
      else if (m_ir != 0 && m_ir != 2) m_byp = d;
    end
    m_st = nx;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  logic [12:0] last_out;
  logic        last_tdo;

  // One tck cycle: drive, sample at the falling edge, check, advance.
  task automatic step(input logic t, input logic d, input logic ice, input logic rst);
    tms = t; tdi = d; icetap_tdo = ice; reset = rst;
    @(negedge tck);
    last_out = dut_vec;
    last_tdo = tdo;
    if (model_valid) check("cycle_outputs", {19'd0, dut_vec}, {19'd0, model_out(ice)});
    model_update(t, d, rst);
    if (rst) model_valid = 1'b1;
    @(posedge tck);
    #1;
  endtask

  // IR scan of n bits from RTI, ending back in RTI; returns tdo seen in SH_IR.
  task automatic ir_scan(input int n, input logic [7:0] data, output logic [7:0] seen);
    seen = '0;
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, data[i], 0, 0);
      seen[i] = last_tdo;
    end
    step(1, 0, 0, 0); step(0, 0, 0, 0);
  endtask

  // DR scan of n bits from RTI, ending back in RTI.
  task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] ice,
                         output logic [31:0] seen, output int sh_cnt);
    seen = '0;
    sh_cnt = 0;
    step(1, 0, 0, 0); sh_cnt += int'(last_out[8]);
    step(0, 0, 0, 0); sh_cnt += int'(last_out[8]);
    step(0, 0, 0, 0); sh_cnt += int'(last_out[8]);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], ice[i], 0);
      seen[i] = last_tdo;
      sh_cnt += int'(last_out[8]);
    end
    step(1, 0, 0, 0); sh_cnt += int'(last_out[8]);
    step(0, 0, 0, 0); sh_cnt += int'(last_out[8]);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0]  ir_seen;
    logic [31:0] dr_seen;
    int          cnt;

    @(posedge tck); #1;

    // Reset
    step(0, 0, 0, 1);
    check("reset_tlr", test_logic_reset, 1);
    check("reset_flags", {extest_ir, scan_n_ir, idcode_ir, bypass_ir}, 4'b0010);
    check("reset_tdo", {tdo, tdo_ena}, 2'b00);
    check("reset_other_strobes",
          {capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir}, 0);
    step(0, 0, 0, 0);
    check("rti_after_reset", test_logic_reset, 0);

    // IDCODE read
    dr_scan(32, 32'h0, 32'h0, dr_seen, cnt);
    check("idcode_read", dr_seen, 32'h1000_0A5F);
    check("idcode_shift_count", cnt, 32);

    // IR capture and SCAN_N load
    ir_scan(4, 8'h02, ir_seen);
    check("ir_capture_tdo", ir_seen[3:0], 4'b0001);
    check("scan_n_flags", {extest_ir, scan_n_ir, idcode_ir, bypass_ir}, 4'b0100);

    // BYPASS: in 1,0,1,1 -> out 0,1,0,1
    ir_scan(4, 8'h0F, ir_seen);
    check("bypass_flag", bypass_ir, 1);
    dr_scan(4, 32'b1101, 32'h0, dr_seen, cnt);
    check("bypass_tdo", dr_seen[3:0], 4'b1010);

    // Undefined opcode decodes as BYPASS
    ir_scan(4, 8'h07, ir_seen);
    check("unknown_is_bypass", {extest_ir, scan_n_ir, idcode_ir, bypass_ir}, 4'b0001);

    // IR over-length: 6 bits shifted, last four (0010) remain
    ir_scan(6, 8'b0010_11, ir_seen);
    check("ir_overlength", {extest_ir, scan_n_ir, idcode_ir, bypass_ir}, 4'b0100);

    // EXTEST: tdo follows icetap_tdo, shift_dr high exactly N cycles
    ir_scan(4, 8'h00, ir_seen);
    check("extest_flag", extest_ir, 1);
    dr_scan(8, 32'h5A, 32'hB4, dr_seen, cnt);
    check("extest_passthrough", dr_seen[7:0], 8'hB4);
    check("extest_shift_count", cnt, 8);
    check("extest_flag_after_dr", extest_ir, 1);

    // TMS recovery from Pause-DR
    ir_scan(4, 8'h02, ir_seen);
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    check("tms_recovery_tlr", test_logic_reset, 1);
    check("tms_recovery_ir", {extest_ir, scan_n_ir, idcode_ir, bypass_ir}, 4'b0010);

    // Reset in the middle of Shift-IR (partial pattern would decode SCAN_N)
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    check("midshift_reset_tlr", {test_logic_reset, shift_ir, tdo_ena}, 3'b100);
    check("midshift_reset_ir", {extest_ir, scan_n_ir, idcode_ir, bypass_ir}, 4'b0010);
    step(0, 0, 0, 0);
    check("midshift_ir_after", idcode_ir, 1);

    // Random tms/tdi/icetap_tdo with occasional reset
    for (int i = 0; i < 4000; i++) begin
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
